sram_arbiter_2x1: RTL and testbench

//  Shares one single-port synchronous SRAM (1-cycle read latency) between the CPU instruction port and data port.

---
 rtl/sram_arbiter_2x1.sv | 93 +++++++++
 tb/tb_sram_arbiter_2x1.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2x1.sv
// Two-master front end for one single-port synchronous SRAM (1-cycle read latency).
// Round-robin on contention, read data routed back to the issuing master, contention counter.
module sram_arbiter_2x1 #(
  parameter int XLEN       = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic [3:0]      inst_wen,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] inst_wdata,
  output logic            inst_gnt,
  output logic            inst_rvalid,
  output logic [XLEN-1:0] inst_rdata,
  input  logic            data_req,
  input  logic [3:0]      data_wen,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] data_wdata,
  output logic            data_gnt,
  output logic            data_rvalid,
  output logic [XLEN-1:0] data_rdata,
  output logic            sram_en,
  output logic [3:0]      sram_wen,
  output logic [XLEN-1:0] sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata,
  output logic [31:0]     conflict_cnt
);

  // Handshake: a master holds req/wen/addr/wdata stable until it sees gnt=1;
  // the transfer happens in the cycle gnt is high. Reads return rvalid one cycle later.

  localparam logic LAST_GRANT_RST = DATA_FIRST ? 1'b0 : 1'b1;

  logic last_grant;   // 0 = inst, 1 = data
  logic resp_valid;
  logic resp_owner;   // 0 = inst, 1 = data

  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
        // The master that did not win last time takes this one.
        inst_gnt = last_grant;
        data_gnt = ~last_grant;
      end else begin
        inst_gnt = inst_req;
        data_gnt = data_req;
      end
    end
  end

  always_comb begin
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_wen   = inst_wen;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (data_gnt) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  assign sram_en = inst_gnt | data_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= LAST_GRANT_RST;
      resp_valid   <= 1'b0;
      resp_owner   <= 1'b0;
      conflict_cnt <= 32'd0;
    end else begin
      if (sram_en) last_grant <= data_gnt;
      resp_valid <= sram_en && (sram_wen == 4'b0000);
      resp_owner <= data_gnt;
      if (inst_req && data_req && (conflict_cnt != 32'hFFFF_FFFF))
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  // A response still in flight when reset arrives is suppressed immediately.
  assign inst_rvalid = resp_valid & ~resp_owner & ~reset;
  assign data_rvalid = resp_valid &  resp_owner & ~reset;
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Bench for sram_arbiter_2x1: behavioural SRAM, transaction-level reference model,
// directed scenarios plus randomized two-master traffic.
module tb_sram_arbiter_2x1;

  localparam int  XLEN       = 32;
  localparam bit  DATA_FIRST = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            inst_req = 1'b0, data_req = 1'b0;
  logic [3:0]      inst_wen = '0, data_wen = '0;
  logic [XLEN-1:0] inst_addr = '0, inst_wdata = '0, data_addr = '0, data_wdata = '0;
  logic            inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
  logic [XLEN-1:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [XLEN-1:0] sram_rdata = '0;
  logic [3:0]      sram_wen;
  logic [31:0]     conflict_cnt;

  sram_arbiter_2x1 #(.XLEN(XLEN), .DATA_FIRST(DATA_FIRST)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  // Behavioural single-port SRAM, word-indexed by addr[13:2].
  logic [31:0] sram_mem [0:4095];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'b0000) sram_rdata <= sram_mem[sram_addr[13:2]];
      else for (int b = 0; b < 4; b++)
        if (sram_wen[b]) sram_mem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:4095];
  bit          prefer_data;        // who wins the next contention
  bit          pend_valid, pend_owner;
  logic [31:0] pend_data;
  logic [31:0] m_cnt;
  logic [31:0] exp_q[$];           // read data expected back, in order
  bit          e_igt, e_dgt, e_en, e_irv, e_drv;
  logic [3:0]  e_wen;
  logic [31:0] e_addr, e_wdata, e_cnt;

  int total = 0;
  int bad   = 0;

  // Apply the transaction that happened at the last edge to the model.
  task automatic model_commit();
    logic [3:0]  w;
    logic [31:0] a, d;
    if (reset) begin
      prefer_data = DATA_FIRST;
      pend_valid  = 0;
      m_cnt       = 0;
      exp_q.delete();
    end else begin
      if (inst_req && data_req && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (pend_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      pend_valid = 0;
      if (e_igt || e_dgt) begin
        w = e_dgt ? data_wen : inst_wen;
        a = e_dgt ? data_addr : inst_addr;
        d = e_dgt ? data_wdata : inst_wdata;
        if (w == 4'b0000) begin
          pend_valid = 1;
          pend_owner = e_dgt;
          pend_data  = ref_mem[a[13:2]];
          exp_q.push_back(pend_data);
        end else begin
          for (int b = 0; b < 4; b++) if (w[b]) ref_mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
        end
        prefer_data = e_igt;
      end
    end
  endtask

  // Expected outputs for the inputs now applied.
  task automatic model_expect();
    e_igt   = !reset && inst_req && (!data_req || !prefer_data);
    e_dgt   = !reset && data_req && (!inst_req || prefer_data);
    e_en    = e_igt || e_dgt;
    e_wen   = e_igt ? inst_wen   : e_dgt ? data_wen   : 4'b0;
    e_addr  = e_igt ? inst_addr  : e_dgt ? data_addr  : 32'b0;
    e_wdata = e_igt ? inst_wdata : e_dgt ? data_wdata : 32'b0;
    e_irv   = !reset && pend_valid && !pend_owner;
    e_drv   = !reset && pend_valid &&  pend_owner;
    e_cnt   = m_cnt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    model_commit();
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic set_inst(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    inst_req = r; inst_wen = w; inst_addr = a; inst_wdata = d;
  endtask

  task automatic set_data(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    data_req = r; data_wen = w; data_addr = a; data_wdata = d;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1;
    for (int i = 0; i < cycles; i++) begin next_cycle(); settle(); end
    next_cycle();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_inst(1, 0, 32'h10, 0);
    set_data(1, 0, 32'h20, 0);
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      total++;
      if (inst_gnt !== 1'b0 || data_gnt !== 1'b0 || sram_en !== 1'b0 || sram_wen !== 4'b0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%b%b en=%b wen=%b, required all zero", inst_gnt, data_gnt, sram_en, sram_wen);
      end
    end
    next_cycle(); reset = 0; settle();
    total++;
    if (data_gnt !== 1'b1 || inst_gnt !== 1'b0 || conflict_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_first_grant: dgnt=%b ignt=%b cnt=%0d, required 1 0 0", data_gnt, inst_gnt, conflict_cnt);
    end
    next_cycle(); set_data(0, 0, 0, 0); settle();
    total++;
    if (conflict_cnt !== 32'd1 || inst_gnt !== 1'b1 || data_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_after: cnt=%0d ignt=%b drvalid=%b, required 1 1 1", conflict_cnt, inst_gnt, data_rvalid);
    end
    next_cycle(); set_inst(0, 0, 0, 0); settle();
  endtask

  task automatic test_inst_read();
    sram_mem[12'h040] = 32'hDEAD_BEEF;
    ref_mem[12'h040]  = 32'hDEAD_BEEF;
    next_cycle(); set_inst(1, 0, 32'h100, 0); settle();
    total++;
    if (inst_gnt !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 32'h100) begin
      bad++;
      $display("FAIL inst_read_gnt: gnt=%b en=%b addr=%h, required 1 1 00000100", inst_gnt, sram_en, sram_addr);
    end
    next_cycle(); set_inst(0, 0, 0, 0); settle();
    total++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF || data_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL inst_read_data: rv=%b rdata=%h drv=%b, required 1 deadbeef 0", inst_rvalid, inst_rdata, data_rvalid);
    end
  endtask

  task automatic test_alternate();
    set_inst(0, 0, 0, 0); set_data(0, 0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      if (i < 6) begin
        set_inst(1, 0, 32'h200 + 4*i, 0);
        set_data(1, 0, 32'h300 + 4*i, 0);
      end else begin
        set_inst(0, 0, 0, 0); set_data(0, 0, 0, 0);
      end
      settle();
      total++;
      if (i < 6 && (data_gnt !== (i % 2 == 0) || inst_gnt !== (i % 2 == 1))) begin
        bad++;
        $display("FAIL alternate_gnt[%0d]: ignt=%b dgnt=%b, required %b %b", i, inst_gnt, data_gnt, i % 2 == 1, i % 2 == 0);
      end else if (i > 0 && (data_rvalid !== ((i - 1) % 2 == 0) || inst_rvalid !== ((i - 1) % 2 == 1))) begin
        bad++;
        $display("FAIL alternate_rvalid[%0d]: irv=%b drv=%b", i, inst_rvalid, data_rvalid);
      end
    end
    total++;
    if (conflict_cnt !== 32'd6) begin
      bad++;
      $display("FAIL alternate_cnt: cnt=%0d, required 6", conflict_cnt);
    end
  endtask

  task automatic test_partial_write();
    next_cycle(); set_data(1, 4'b0011, 32'h40, 32'h1234_5678); settle();
    total++;
    if (data_gnt !== 1'b1 || sram_wen !== 4'b0011 || sram_wdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_drive: gnt=%b wen=%b wdata=%h, required 1 0011 12345678", data_gnt, sram_wen, sram_wdata);
    end
    next_cycle(); set_data(0, 0, 0, 0); set_inst(1, 0, 32'h40, 0); settle();
    total++;
    if (inst_gnt !== 1'b1 || data_rvalid !== 1'b0 || inst_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL write_norvalid: ignt=%b drv=%b irv=%b, required 1 0 0", inst_gnt, data_rvalid, inst_rvalid);
    end
    next_cycle(); set_inst(0, 0, 0, 0); settle();
    total++;
    if (inst_rvalid !== 1'b1 || inst_rdata[15:0] !== 16'h5678 || inst_rdata !== exp_q[0]) begin
      bad++;
      $display("FAIL write_readback: rv=%b rdata=%h, required 1 %h", inst_rvalid, inst_rdata, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle(); set_data(1, 0, 32'h80, 0); settle();
    next_cycle(); set_data(0, 0, 0, 0); reset = 1; settle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL reset_drop[%0d]: drv=%b irv=%b, required 0 0", i, data_rvalid, inst_rvalid);
      end
      next_cycle(); reset = 0; settle();
    end
  endtask

  task automatic test_saturate();
    next_cycle();
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1 release dut.conflict_cnt;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      set_inst(i < 3, 0, 32'h10, 0); set_data(i < 3, 0, 32'h14, 0);
      settle();
      total++;
      if (conflict_cnt !== e_cnt) begin
        bad++;
        $display("FAIL saturate[%0d]: cnt=%h, required %h", i, conflict_cnt, e_cnt);
      end
    end
    total++;
    if (conflict_cnt !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL saturate_final: cnt=%h, required ffffffff", conflict_cnt);
    end
  endtask

  task automatic test_random();
    bit ip = 0, dp = 0;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      if (e_igt) ip = 0;
      if (e_dgt) dp = 0;
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1;
        set_inst(1, ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15)),
                 32'($urandom_range(0, 15)) << 2, $urandom);
      end else if (!ip) set_inst(0, 0, 0, 0);
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1;
        set_data(1, ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15)),
                 32'($urandom_range(0, 15)) << 2, $urandom);
      end else if (!dp) set_data(0, 0, 0, 0);
      settle();
      total++;
      if (inst_gnt !== e_igt || data_gnt !== e_dgt || sram_en !== e_en || sram_wen !== e_wen ||
          sram_addr !== e_addr || sram_wdata !== e_wdata) begin
        bad++;
        $display("FAIL rand_drive[%0d]: gnt=%b%b en=%b wen=%b addr=%h wd=%h, required %b%b %b %b %h %h",
                 n, inst_gnt, data_gnt, sram_en, sram_wen, sram_addr, sram_wdata,
                 e_igt, e_dgt, e_en, e_wen, e_addr, e_wdata);
      end
      total++;
      if (inst_rvalid !== e_irv || data_rvalid !== e_drv || conflict_cnt !== e_cnt ||
          ((e_irv || e_drv) && (exp_q.size() == 0 || (e_irv ? inst_rdata : data_rdata) !== exp_q[0]))) begin
        bad++;
        $display("FAIL rand_resp[%0d]: rv=%b%b rdata=%h cnt=%0d, required %b%b %h %0d",
                 n, inst_rvalid, data_rvalid, e_irv ? inst_rdata : data_rdata, conflict_cnt,
                 e_irv, e_drv, pend_data, e_cnt);
      end
    end
    next_cycle(); set_inst(0, 0, 0, 0); set_data(0, 0, 0, 0); settle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 4096; i++) begin sram_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    test_reset();
    test_inst_read();
    test_alternate();
    test_partial_write();
    test_reset_mid_read();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
